room_gate_sequencer: RTL and testbench



---
 rtl/room_pkg.sv | 20 ++
 rtl/room_rr_arbiter.sv | 37 +++
 rtl/room_gate_sequencer.sv | 139 +++++++++++++
 tb/tb_room_gate_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/room_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | room_pkg : shared state encoding and default sizing for the room     |
// |            gate sequencer                                            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package room_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    OPEN_WAIT = 2'd1,
    HOLDOFF   = 2'd2
  } state_t;

  localparam int c_cap_default     = 15;
  localparam int c_cw_default      = 4;
  localparam int c_timeout_default = 8;

endpackage
`default_nettype wire

// File: rtl/room_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | room_rr_arbiter : combinational round-robin pick, first requester at |
// |                   or after the pointer, wrapping                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module room_rr_arbiter
  import room_pkg::*;
#(
  parameter int N_GATES = 2,
  parameter int PW      = 1
) (
  input  logic [N_GATES-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [N_GATES-1:0] gnt,
  output logic [PW-1:0]      idx,
  output logic               valid
);

  always_comb begin
    int k;
    k     = 0;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N_GATES; i++) begin
      k = (int'(ptr) + i) % N_GATES;
      if (!valid && req[k]) begin
        valid  = 1'b1;
        gnt[k] = 1'b1;
        idx    = PW'(k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/room_gate_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | room_gate_sequencer : shared door sequencing for an occupancy-limited|
// |                       room with round-robin entry gates              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module room_gate_sequencer
  import room_pkg::*;
#(
  parameter int N_GATES = 2,
  parameter int CAP     = c_cap_default,
  parameter int CW      = c_cw_default,
  parameter int TIMEOUT = c_timeout_default
) (
  input  logic               clk,
  input  logic               CLRN,
  input  logic               T,
  input  logic [N_GATES-1:0] ENT_REQ,
  input  logic [N_GATES-1:0] IN_SENSE,
  input  logic               OUT_SENSE,
  output logic [N_GATES-1:0] OPEN,
  output logic               CLOSE,
  output logic               DENY,
  output logic [CW-1:0]      COUNT,
  output logic               FULL
);

  localparam int PW = (N_GATES > 1) ? $clog2(N_GATES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] c_cap   = CW'(CAP);
  localparam logic [TW-1:0] c_tlast = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] c_plast = PW'(N_GATES - 1);

  state_t             r_state, w_state_nxt;
  logic [PW-1:0]      r_ptr, w_ptr_nxt;
  logic [PW-1:0]      r_gidx, w_gidx_nxt;
  logic [TW-1:0]      r_timer, w_timer_nxt;
  logic [N_GATES-1:0] r_open, w_open_nxt;
  logic               r_close, r_deny, w_deny_nxt, r_full;
  logic [CW-1:0]      r_count, w_count_nxt;
  logic               w_inc, w_dec;
  logic [N_GATES-1:0] w_arb_gnt;
  logic [PW-1:0]      w_arb_idx;
  logic               w_arb_valid;

  room_rr_arbiter #(
    .N_GATES (N_GATES),
    .PW      (PW)
  ) u_arb (
    .req   (ENT_REQ),
    .ptr   (r_ptr),
    .gnt   (w_arb_gnt),
    .idx   (w_arb_idx),
    .valid (w_arb_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gidx_nxt  = r_gidx;
    w_timer_nxt = r_timer;
    w_open_nxt  = '0;
    w_deny_nxt  = 1'b0;
    w_inc       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_valid) begin
          if (T && (r_count < c_cap)) begin
            w_state_nxt = OPEN_WAIT;
            w_gidx_nxt  = w_arb_idx;
            w_open_nxt  = w_arb_gnt;
            w_timer_nxt = '0;
          end else begin
            w_deny_nxt = 1'b1;
          end
        end
      end
      OPEN_WAIT: begin
        // A pass wins over timeout and T dropping in the same cycle.
        if (IN_SENSE[r_gidx]) begin
          w_inc       = (r_count < c_cap);
          w_state_nxt = HOLDOFF;
        end else if ((r_timer == c_tlast) || !T) begin
          w_state_nxt = HOLDOFF;
        end else begin
          w_open_nxt  = r_open;
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      HOLDOFF: begin
        w_ptr_nxt   = (r_gidx == c_plast) ? '0 : r_gidx + 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Entry and exit in the same cycle cancel out.
  always_comb begin
    w_dec       = OUT_SENSE && (r_count != '0);
    w_count_nxt = r_count;
    if (w_inc && !OUT_SENSE)
      w_count_nxt = r_count + 1'b1;
    else if (!w_inc && w_dec)
      w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk or negedge CLRN) begin
    if (!CLRN) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_timer <= '0;
      r_open  <= '0;
      r_close <= 1'b1;
      r_deny  <= 1'b0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gidx  <= w_gidx_nxt;
      r_timer <= w_timer_nxt;
      r_open  <= w_open_nxt;
      r_close <= ~|w_open_nxt;
      r_deny  <= w_deny_nxt;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_cap);
    end
  end

  assign OPEN  = r_open;
  assign CLOSE = r_close;
  assign DENY  = r_deny;
  assign COUNT = r_count;
  assign FULL  = r_full;

endmodule
`default_nettype wire

// File: tb/tb_room_gate_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_room_gate_sequencer : directed + random bench with an occupancy / |
// |                          door-window reference model                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_room_gate_sequencer;

  localparam int N       = 2;
  localparam int CAP     = 15;
  localparam int TIMEOUT = 8;

  logic         clk = 1'b0;
  logic         CLRN, T, OUT_SENSE;
  logic [N-1:0] ENT_REQ, IN_SENSE;
  logic [N-1:0] OPEN;
  logic         CLOSE, DENY, FULL;
  logic [3:0]   COUNT;

  int errors = 0;
  int checks = 0;

  // Reference model: which gate's door is open (-1 none), how long it has
  // been open, whether the door just closed, next gate in turn, occupancy.
  int m_door, m_age, m_next, m_occ;
  bit m_cool, m_deny;

  room_gate_sequencer #(
    .N_GATES (N), .CAP (CAP), .CW (4), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk), .CLRN (CLRN), .T (T), .ENT_REQ (ENT_REQ),
    .IN_SENSE (IN_SENSE), .OUT_SENSE (OUT_SENSE), .OPEN (OPEN),
    .CLOSE (CLOSE), .DENY (DENY), .COUNT (COUNT), .FULL (FULL)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_door = -1; m_age = 0; m_next = 0; m_occ = 0; m_cool = 0; m_deny = 0;
  endtask

  task automatic model_step(input logic t, input logic [N-1:0] req,
                            input logic [N-1:0] ins, input logic outs);
    bit entered;
    entered = 0;
    m_deny  = 0;
    if (m_door >= 0) begin
      if (ins[m_door] || m_age == TIMEOUT || !t) begin
        entered = ins[m_door] && (m_occ < CAP);
        m_next  = (m_door + 1) % N;
        m_door  = -1;
        m_cool  = 1;
      end else begin
        m_age++;
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else if (req != '0) begin
      if (t && m_occ < CAP) begin
        for (int i = 0; i < N; i++)
          if (m_door < 0 && req[(m_next + i) % N]) m_door = (m_next + i) % N;
        m_age = 1;
      end else begin
        m_deny = 1;
      end
    end
    if (entered && outs) m_occ = m_occ;
    else if (entered) m_occ++;
    else if (outs && m_occ > 0) m_occ--;
  endtask

  task automatic check_all();
    logic [N-1:0] eo;
    eo = '0;
    if (m_door >= 0) eo[m_door] = 1'b1;
    chk("open", 32'(OPEN), 32'(eo));
    chk("close", 32'(CLOSE), 32'(m_door < 0));
    chk("deny", 32'(DENY), 32'(m_deny));
    chk("count", 32'(COUNT), 32'(m_occ));
    chk("full", 32'(FULL), 32'(m_occ == CAP));
    chk("onehot", 32'($countones(OPEN) <= 1), 32'd1);
  endtask

  task automatic cyc(input logic t, input logic [N-1:0] req,
                     input logic [N-1:0] ins, input logic outs);
    T = t; ENT_REQ = req; IN_SENSE = ins; OUT_SENSE = outs;
    @(posedge clk);
    #1;
    model_step(t, req, ins, outs);
    check_all();
  endtask

  task automatic do_reset();
    CLRN = 1'b0; T = 1'b0; ENT_REQ = '0; IN_SENSE = '0; OUT_SENSE = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_all();
    CLRN = 1'b1;
  endtask

  // Requests until a door opens, then passes on open cycle pass_at (0 = never).
  task automatic run_window(input logic [N-1:0] req, input int pass_at,
                            input logic out_with_pass, output logic [N-1:0] first_open);
    int guard;
    guard = 0;
    first_open = '0;
    while (m_door < 0 && guard < 20) begin
      cyc(1'b1, req, '0, 1'b0);
      guard++;
    end
    if (m_door < 0) begin
      chk("grant_wait", 32'd0, 32'd1);
      return;
    end
    first_open = OPEN;
    for (int a = 1; m_door >= 0 && a <= TIMEOUT + 1; a++) begin
      if (a == pass_at) cyc(1'b1, req, N'(1 << m_door), out_with_pass);
      else              cyc(1'b1, req, '0, 1'b0);
    end
  endtask

  initial begin
    logic [N-1:0] fo;
    logic [N-1:0] rr_exp [3];
    int n_open;
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01;

    // Reset values and first pass-through
    do_reset();
    chk("rst_close", 32'(CLOSE), 32'd1);
    cyc(1'b1, 2'b01, 2'b00, 1'b0);
    chk("t1_open", 32'(OPEN), 32'h1);
    cyc(1'b1, 2'b01, 2'b00, 1'b0);
    cyc(1'b0 | 1'b1, 2'b00, 2'b01, 1'b0);
    chk("t1_count", 32'(COUNT), 32'd1);
    chk("t1_closed", 32'(OPEN), 32'd0);
    chk("t1_close", 32'(CLOSE), 32'd1);
    cyc(1'b1, 2'b00, 2'b00, 1'b0);

    // Round-robin with both gates requesting
    do_reset();
    for (int w = 0; w < 3; w++) begin
      run_window(2'b11, 2, 1'b0, fo);
      chk("rr_order", 32'(fo), 32'(rr_exp[w]));
    end
    chk("rr_count", 32'(COUNT), 32'd3);

    // Fill to capacity, denial, exit at full, then re-grant
    for (int w = 0; w < CAP - 3; w++) run_window(2'b01, 1, 1'b0, fo);
    cyc(1'b1, 2'b00, 2'b00, 1'b0);
    chk("fill_full", 32'(FULL), 32'd1);
    cyc(1'b1, 2'b01, 2'b00, 1'b0);
    chk("full_deny", 32'(DENY), 32'd1);
    cyc(1'b1, 2'b01, 2'b00, 1'b1);
    chk("full_out_deny", 32'(DENY), 32'd1);
    chk("full_out_count", 32'(COUNT), 32'd14);
    cyc(1'b1, 2'b01, 2'b00, 1'b0);
    chk("regrant", 32'(OPEN), 32'h1);
    for (int i = 0; i < TIMEOUT; i++) cyc(1'b1, 2'b00, 2'b00, 1'b0);

    // Unused window stays open exactly TIMEOUT cycles
    do_reset();
    cyc(1'b1, 2'b10, 2'b00, 1'b0);
    n_open = 0;
    for (int i = 0; i < 20 && OPEN != '0; i++) begin
      n_open++;
      cyc(1'b1, 2'b00, 2'b00, 1'b0);
    end
    chk("timeout_len", 32'(n_open), 32'(TIMEOUT));
    chk("timeout_count", 32'(COUNT), 32'd0);

    // Simultaneous entry/exit, and exit at zero
    do_reset();
    for (int w = 0; w < 5; w++) run_window(2'b01, 2, 1'b0, fo);
    run_window(2'b01, 2, 1'b1, fo);
    chk("in_out_same", 32'(COUNT), 32'd5);
    do_reset();
    cyc(1'b1, 2'b00, 2'b00, 1'b1);
    chk("out_at_zero", 32'(COUNT), 32'd0);

    // T=0 refuses, T falling closes, async reset mid-window
    cyc(1'b0, 2'b10, 2'b00, 1'b0);
    chk("t0_deny", 32'(DENY), 32'd1);
    chk("t0_noopen", 32'(OPEN), 32'd0);
    cyc(1'b1, 2'b01, 2'b00, 1'b0);
    cyc(1'b1, 2'b01, 2'b00, 1'b0);
    cyc(1'b0, 2'b01, 2'b00, 1'b0);
    chk("t_fall_close", 32'(OPEN), 32'd0);
    cyc(1'b1, 2'b00, 2'b00, 1'b0);
    run_window(2'b10, 1, 1'b0, fo);
    cyc(1'b1, 2'b01, 2'b00, 1'b0);
    cyc(1'b1, 2'b01, 2'b00, 1'b0);
    chk("pre_rst_open", 32'(OPEN), 32'h1);
    CLRN = 1'b0;
    #2;
    chk("async_open", 32'(OPEN), 32'd0);
    chk("async_count", 32'(COUNT), 32'd0);
    chk("async_close", 32'(CLOSE), 32'd1);
    model_reset();
    CLRN = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic         rt, ro;
      logic [N-1:0] rq, ri;
      rt = ($urandom_range(0, 7) != 0);
      rq = N'($urandom);
      ri = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      ro = ($urandom_range(0, 5) == 0);
      cyc(rt, rq, ri, ro);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
